vp_lut_banked: RTL and testbench
================================

# vp_lut_banked

Parametrised, runtime-programmable per-channel look-up-table pixel processor for the HDMI video path. Sits between the HDMI input decoder and the HDMI output encoder, replacing the fixed single-table `vp_0` stage. Each colour channel has its own double-buffered table. New tables and a new per-channel enable mask load into shadow banks while video runs, then commit atomically at the next frame boundary (rising edge of `v_sync_in`). Sync and enable signals are delayed to match the pixel latency exactly.

## Interface
Parameters:
- `DATA_W`, 8, bits per colour channel; table depth is 2^DATA_W.
- `CHANNELS`, 3, number of channels packed in one pixel word.
- `CH_W`, 2, width of the channel-select field; must satisfy 2^CH_W >= CHANNELS.

Ports:
- `clk`  in  1  pixel clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `de_in`  in  1  data enable.
- `h_sync_in`  in  1  horizontal sync.
- `v_sync_in`  in  1  vertical sync, active-high.
- `pixel_in`  in  CHANNELS*DATA_W  pixel; channel k occupies bits [k*DATA_W +: DATA_W].
- `de_out`  out  1  `de_in` delayed 2 cycles.
- `h_sync_out`  out  1  `h_sync_in` delayed 2 cycles.
- `v_sync_out`  out  1  `v_sync_in` delayed 2 cycles.
- `pixel_out`  out  CHANNELS*DATA_W  processed pixel, same packing as `pixel_in`.
- `lut_we`  in  1  table write strobe; writes the shadow bank.
- `lut_ch`  in  CH_W  channel to write.
- `lut_addr`  in  DATA_W  table entry to write.
- `lut_wdata`  in  DATA_W  value to write.
- `mask_in`  in  CHANNELS  shadow enable mask. Bit k = 1 means channel k goes through its LUT; 0 means bypass.
- `swap_req`  in  1  single-cycle request to commit the shadow banks and the mask.
- `swap_pending`  out  1  high from request until commit.
- `swap_done`  out  1  one-cycle pulse on the cycle the commit takes effect.

## Operation
- Storage:
  - Per channel, two RAM banks of 2^DATA_W x DATA_W.
  - A single `active_bank` bit selects the read bank for all channels. The other bank is the shadow bank.
- Write path:
  - When `lut_we`=1 and `lut_ch`<CHANNELS, write `lut_wdata` to shadow[`lut_ch`][`lut_addr`].
  - When `lut_ch`>=CHANNELS, ignore the write.
  - Writes never touch the active bank.
- Mask:
  - `mask_in` is captured into `mask_shadow` every cycle that `swap_req`=1.
  - `mask_active` is the mask in use. It updates only on commit.
- Swap state machine:
  - IDLE -> PENDING when `swap_req`=1.
  - PENDING -> IDLE on a rising edge of `v_sync_in` (previous sample 0, current 1). On that transition:
    - toggle `active_bank`;
    - `mask_active` <= `mask_shadow`;
    - pulse `swap_done` for one cycle.
  - `swap_req` while in PENDING: recapture `mask_shadow` and stay in PENDING.
  - `swap_req` in the same cycle as a v-sync rising edge while in IDLE: enter PENDING only. Commit waits for the next frame edge.
- Datapath, per channel k:
  - Stage 1: register the channel value; issue a synchronous read of active[k] at that value.
  - Stage 2: `pixel_out` channel k = RAM data if `mask_active`[k], otherwise the stage-1 registered value.
  - Both paths have identical latency.
- Pixels are processed regardless of `de_in`. Blanking data passes through the same path.

## Timing
- Latency: 2 cycles, input to `pixel_out`. `de`, `h_sync` and `v_sync` use matched 2-stage delay lines.
- `active_bank` and `mask_active` change in the cycle after the v-sync edge is detected. The first pixel affected is the one sampled on that cycle.
- Write-to-read: a write becomes visible only after a commit. A write in the same cycle as the commit lands in the bank that becomes active.
- Reset values, asynchronous while `rst_n`=0:
  - all outputs 0;
  - all delay registers 0;
  - `active_bank`=0, `mask_active`=0 (full bypass), `mask_shadow`=0;
  - state IDLE, v-sync edge detector's previous sample = 0.
- RAM contents are not reset.
- Reset mid-frame or while PENDING aborts the commit; shadow writes already made remain.

## Test plan
- Reset, then bypass: drive `pixel_in`=0x123456 with `de_in`=1 -> `pixel_out`=0x123456 and `de_out`=1 exactly 2 cycles later. All outputs are 0 during reset.
- Invert LUT, one commit:
  - write shadow[k][a]=255-a for k=0..2;
  - pulse `swap_req` with `mask_in`=3'b111, then raise `v_sync_in`;
  - expect `swap_done` on the edge, and pixel 0x10F080 -> 0xEF0F7F after commit. Before the edge, output stays 0x10F080.
- Partial mask: the same tables with `mask_in`=3'b010 -> 0x10F080 -> 0x100F80.
- Shadow isolation: after the commit, write shadow[0][0x80]=0x00 without `swap_req` -> active output is unchanged across two frames.
- Request and v-sync edge in the same cycle, in IDLE -> no commit on that edge. `swap_pending`=1 until the next edge, then `swap_done` pulses.
- Abort and invalid write:
  - `lut_we` with `lut_ch`=3 -> no table changes;
  - assert `rst_n`=0 while PENDING -> `swap_pending`=0, `mask_active`=0, output in bypass.

Source files
------------

// File: rtl/vp_lut_banked.sv
// rtl/vp_lut_banked.sv - per-channel double-buffered LUT pixel stage with frame-boundary commit
module vp_lut_banked #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int CH_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         de_in,
    input  logic                         h_sync_in,
    input  logic                         v_sync_in,
    input  logic [CHANNELS*DATA_W-1:0]   pixel_in,
    output logic                         de_out,
    output logic                         h_sync_out,
    output logic                         v_sync_out,
    output logic [CHANNELS*DATA_W-1:0]   pixel_out,
    input  logic                         lut_we,
    input  logic [CH_W-1:0]              lut_ch,
    input  logic [DATA_W-1:0]            lut_addr,
    input  logic [DATA_W-1:0]            lut_wdata,
    input  logic [CHANNELS-1:0]          mask_in,
    input  logic                         swap_req,
    output logic                         swap_pending,
    output logic                         swap_done
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t                       state, state_nxt;
    logic                         commit;
    logic                         vs_prev;
    logic                         vs_rise;
    logic                         active_bank;
    logic [CHANNELS-1:0]          mask_shadow;
    logic [CHANNELS-1:0]          mask_active;
    logic [CHANNELS-1:0]          mask_s1;
    logic [CHANNELS*DATA_W-1:0]   s1_pix;
    logic [CHANNELS*DATA_W-1:0]   pixel_nxt;
    logic [1:0]                   de_d, hs_d, vs_d;

    assign vs_rise      = v_sync_in & ~vs_prev;
    assign swap_pending = (state == PENDING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (swap_req) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (vs_rise) begin
                    state_nxt = IDLE;
                    commit    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev     <= 1'b0;
            active_bank <= 1'b0;
            mask_shadow <= '0;
            mask_active <= '0;
            swap_done   <= 1'b0;
        end else begin
            vs_prev   <= v_sync_in;
            swap_done <= commit;
            if (swap_req) begin
                mask_shadow <= mask_in;
            end
            if (commit) begin
                active_bank <= ~active_bank;
                mask_active <= mask_shadow;
            end
        end
    end

    // The mask travels with the pixel so a commit never splits one pixel across old and new settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pix     <= '0;
            mask_s1    <= '0;
            pixel_out  <= '0;
            de_d       <= '0;
            hs_d       <= '0;
            vs_d       <= '0;
        end else begin
            s1_pix     <= pixel_in;
            mask_s1    <= mask_active;
            pixel_out  <= pixel_nxt;
            de_d       <= {de_d[0], de_in};
            hs_d       <= {hs_d[0], h_sync_in};
            vs_d       <= {vs_d[0], v_sync_in};
        end
    end

    assign de_out     = de_d[1];
    assign h_sync_out = hs_d[1];
    assign v_sync_out = vs_d[1];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        // Both banks share one array; the bank bit is the address MSB.
        logic [DATA_W-1:0] mem [2**(DATA_W+1)];
        logic [DATA_W-1:0] rd;

        always_ff @(posedge clk) begin
            if (lut_we && (lut_ch == CH_W'(k))) begin
                mem[{~active_bank, lut_addr}] <= lut_wdata;
            end
            rd <= mem[{active_bank, pixel_in[k*DATA_W +: DATA_W]}];
        end

        assign pixel_nxt[k*DATA_W +: DATA_W] = mask_s1[k] ? rd : s1_pix[k*DATA_W +: DATA_W];
    end

endmodule

// File: tb/tb_vp_lut_banked.sv
// tb/tb_vp_lut_banked.sv - scoreboard bench for vp_lut_banked
module tb_vp_lut_banked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de_in, h_sync_in, v_sync_in;
    logic [23:0] pixel_in;
    logic        de_out, h_sync_out, v_sync_out;
    logic [23:0] pixel_out;
    logic        lut_we;
    logic [1:0]  lut_ch;
    logic [7:0]  lut_addr, lut_wdata;
    logic [2:0]  mask_in;
    logic        swap_req;
    logic        swap_pending, swap_done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    vp_lut_banked dut (
        .clk(clk), .rst_n(rst_n),
        .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .pixel_in(pixel_in),
        .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out),
        .lut_we(lut_we), .lut_ch(lut_ch), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
        .mask_in(mask_in), .swap_req(swap_req),
        .swap_pending(swap_pending), .swap_done(swap_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid output pixel is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && de_out) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pixel_unexpected: got 0x%0h expected no pixel", pixel_out);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if (pixel_out !== e) begin
                    n_err++;
                    $display("FAIL pixel_out: got 0x%0h expected 0x%0h", pixel_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [23:0] p, input logic [23:0] e);
        pixel_in = p;
        de_in    = 1'b1;
        exp_q.push_back(e);
        tick();
        de_in    = 1'b0;
        pixel_in = 24'h0;
        repeat (3) tick();
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] a, input logic [7:0] d);
        lut_we    = 1'b1;
        lut_ch    = ch;
        lut_addr  = a;
        lut_wdata = d;
        tick();
        lut_we    = 1'b0;
    endtask

    task automatic write_invert();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 256; a++) begin
                wr(2'(k), 8'(a), 8'(255 - a));
            end
        end
    endtask

    task automatic request(input logic [2:0] m);
        swap_req = 1'b1;
        mask_in  = m;
        tick();
        swap_req = 1'b0;
    endtask

    // Raise v-sync; returns one tick after the rising-edge sample.
    task automatic vs_rise();
        v_sync_in = 1'b1;
        tick();
    endtask

    task automatic vs_fall();
        v_sync_in = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; de_in = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b0;
        pixel_in = 24'hABCDEF; lut_we = 1'b0; lut_ch = 2'd0; lut_addr = 8'd0;
        lut_wdata = 8'd0; mask_in = 3'b000; swap_req = 1'b0;
        repeat (3) tick();
        check("rst_pixel_out", 32'(pixel_out), 32'h0);
        check("rst_de_out", 32'(de_out), 32'h0);
        check("rst_h_sync_out", 32'(h_sync_out), 32'h0);
        check("rst_pending", 32'(swap_pending), 32'h0);
        check("rst_done", 32'(swap_done), 32'h0);
        de_in = 1'b0; h_sync_in = 1'b0; pixel_in = 24'h0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Bypass and exact 2-cycle latency
        pixel_in = 24'h123456; de_in = 1'b1;
        exp_q.push_back(24'h123456);
        tick();
        de_in = 1'b0; pixel_in = 24'h0;
        check("latency_de_early", 32'(de_out), 32'h0);
        tick();
        check("latency_de_on_time", 32'(de_out), 32'h1);
        repeat (3) tick();

        // Full invert commit
        write_invert();
        request(3'b111);
        check("pending_after_req", 32'(swap_pending), 32'h1);
        send_pix(24'h10F080, 24'h10F080);
        check("no_done_before_edge", 32'(swap_done), 32'h0);
        vs_rise();
        check("done_on_commit", 32'(swap_done), 32'h1);
        check("pending_clear", 32'(swap_pending), 32'h0);
        send_pix(24'h10F080, 24'hEF0F7F);
        check("done_one_cycle", 32'(swap_done), 32'h0);
        vs_fall();

        // Partial mask, same tables in the new shadow bank
        write_invert();
        request(3'b010);
        vs_rise();
        check("done_partial", 32'(swap_done), 32'h1);
        send_pix(24'h10F080, 24'h100F80);
        vs_fall();

        // Shadow writes without a request stay invisible for two frames
        wr(2'd0, 8'h80, 8'h00);
        wr(2'd1, 8'hF0, 8'h55);
        for (int f = 0; f < 2; f++) begin
            vs_rise();
            check("iso_no_done", 32'(swap_done), 32'h0);
            send_pix(24'h10F080, 24'h100F80);
            vs_fall();
        end

        // Request coincident with a v-sync edge in IDLE defers commit
        swap_req = 1'b1; mask_in = 3'b111; v_sync_in = 1'b1;
        tick();
        swap_req = 1'b0;
        check("coincident_no_done", 32'(swap_done), 32'h0);
        check("coincident_pending", 32'(swap_pending), 32'h1);
        send_pix(24'h10F080, 24'h100F80);
        vs_fall();
        check("still_pending", 32'(swap_pending), 32'h1);
        vs_rise();
        check("deferred_done", 32'(swap_done), 32'h1);
        send_pix(24'h10F080, 24'hEF5500);
        vs_fall();

        // Out-of-range channel write is dropped
        wr(2'd3, 8'h80, 8'h33);
        wr(2'd3, 8'hF0, 8'h33);
        request(3'b111);
        vs_rise();
        check("invalid_wr_done", 32'(swap_done), 32'h1);
        send_pix(24'h10F080, 24'hEF0F7F);
        vs_fall();

        // Reset while pending aborts the commit
        request(3'b010);
        check("abort_pending_set", 32'(swap_pending), 32'h1);
        rst_n = 1'b0;
        tick();
        check("abort_pending_clr", 32'(swap_pending), 32'h0);
        check("abort_pixel_out", 32'(pixel_out), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();
        vs_rise();
        check("abort_no_done", 32'(swap_done), 32'h0);
        send_pix(24'h10F080, 24'h10F080);
        vs_fall();

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
